// File: rtl/gpr_pkg.sv
// +--------------------------------------------------------------------+
// | gpr_pkg -- shared types and helpers for the gpr_file register file |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package gpr_pkg;

    typedef enum logic [0:0] {
        GPR_IDLE  = 1'b0,
        GPR_SWEEP = 1'b1
    } gpr_state_e;

    // Index width for a file of nreg entries; never narrower than one bit.
    function automatic int gpr_aw(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpr_file_if.sv
// +--------------------------------------------------------------------+
// | gpr_file_if -- write / reserve / clear / read bundle of gpr_file   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface gpr_file_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = gpr_pkg::gpr_aw(NREG);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  clr_req;
    logic                  ready;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clr_req,
        output rd_data, rd_busy, ready
    );

endinterface

`default_nettype wire

// File: rtl/gpr_scoreboard.sv
// +--------------------------------------------------------------------+
// | gpr_scoreboard -- per-register busy bits with NRD lookup ports     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module gpr_scoreboard #(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_set_en,
    input  wire logic [AW-1:0]     i_set_addr,
    input  wire logic              i_clr_en,
    input  wire logic [AW-1:0]     i_clr_addr,
    input  wire logic              i_swp_en,
    input  wire logic [AW-1:0]     i_swp_addr,
    input  wire logic [NRD*AW-1:0] i_lk_addr,
    output logic [NRD-1:0]         o_lk_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-cycle reserve outranks writeback.
    always_comb begin
        busy_d = busy_q;
        if (i_clr_en) busy_d[i_clr_addr] = 1'b0;
        if (i_set_en) busy_d[i_set_addr] = 1'b1;
        if (i_swp_en) busy_d[i_swp_addr] = 1'b0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_lk
            assign o_lk_busy[k] = busy_q[i_lk_addr[k*AW +: AW]];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/gpr_file.sv
// +--------------------------------------------------------------------+
// | gpr_file -- parametrised register file, bypass, busy, clear sweep  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module gpr_file
    import gpr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  wire logic WrClk,
    input  wire logic rst_n,
    gpr_file_if.slave bus
);

    localparam int            AW         = gpr_aw(NREG);
    localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);

    gpr_state_e      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic           w_ready;
    logic           w_wr_fire;
    logic           w_rsv_fire;
    logic           w_swp_en;
    logic [NRD-1:0] w_sb_busy;

    assign w_ready    = (state_q == GPR_IDLE);
    assign w_wr_fire  = w_ready & bus.wr_en & (bus.wr_addr != '0);
    assign w_rsv_fire = w_ready & bus.rsv_en & (bus.rsv_addr != '0);
    assign w_swp_en   = (state_q == GPR_SWEEP);
    assign bus.ready  = w_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        if (w_wr_fire) regs_d[bus.wr_addr] = bus.wr_data;
        case (state_q)
            GPR_IDLE: begin
                if (bus.clr_req) begin
                    state_d = GPR_SWEEP;
                    idx_d   = AW'(1);
                end
            end
            GPR_SWEEP: begin
                regs_d[idx_q] = '0;
                if (idx_q == c_last_idx) begin
                    state_d = GPR_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: state_d = GPR_IDLE;
        endcase
        regs_d[0] = '0;
    end

    always_ff @(posedge WrClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GPR_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            regs_q  <= regs_d;
        end
    end

    gpr_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (WrClk),
        .rst_n      (rst_n),
        .i_set_en   (w_rsv_fire),
        .i_set_addr (bus.rsv_addr),
        .i_clr_en   (w_wr_fire),
        .i_clr_addr (bus.wr_addr),
        .i_swp_en   (w_swp_en),
        .i_swp_addr (idx_q),
        .i_lk_addr  (bus.rd_addr),
        .o_lk_busy  (w_sb_busy)
    );

    // w_wr_fire already excludes index 0 and the sweep, so a hit needs only the address match.
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_hit;
            assign w_ra  = bus.rd_addr[k*AW +: AW];
            assign w_hit = (BYPASS != 0) && w_wr_fire && (bus.wr_addr == w_ra);
            assign bus.rd_data[k*XLEN +: XLEN] = w_hit ? bus.wr_data : regs_q[w_ra];
            assign bus.rd_busy[k] = w_sb_busy[k] & ~w_hit;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_gpr_file.sv
// +--------------------------------------------------------------------+
// | tb_gpr_file -- directed self-checking bench for gpr_file           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_gpr_file;

    logic WrClk = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 WrClk = ~WrClk;

    // A: default 32x32, two ports, bypass on.  B: 16x64, three ports, bypass off.
    gpr_file_if #(.XLEN(32), .NREG(32), .NRD(2)) ia ();
    gpr_file_if #(.XLEN(64), .NREG(16), .NRD(3)) ib ();

    gpr_file #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut_a (
        .WrClk (WrClk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    gpr_file #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(0)) dut_b (
        .WrClk (WrClk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge WrClk);
        #1;
    endtask

    task automatic rda(input int p0, input int p1);
        ia.rd_addr = {5'(p1), 5'(p0)};
    endtask

    function automatic logic [63:0] fb(input int i);
        return (i == 0) ? 64'h0 : {32'hC0DE_0000 + 32'(i), 32'(i * 3)};
    endfunction

    initial begin
        int cnt;
        ia.wr_en = 0; ia.wr_addr = '0; ia.wr_data = '0; ia.rd_addr = '0;
        ia.rsv_en = 0; ia.rsv_addr = '0; ia.clr_req = 0;
        ib.wr_en = 0; ib.wr_addr = '0; ib.wr_data = '0; ib.rd_addr = '0;
        ib.rsv_en = 0; ib.rsv_addr = '0; ib.clr_req = 0;

        step(); step();
        chk("reset_ready", 64'(ia.ready), 64'h1);
        chk("reset_busy", 64'(ia.rd_busy), 64'h0);
        rda(5, 31); #1;
        chk("reset_data", 64'(ia.rd_data), 64'h0);
        rst_n = 1'b1;
        step();

        // B: no bypass, old value this cycle and new value next cycle
        ib.wr_en = 1; ib.wr_addr = 4'd7; ib.wr_data = 64'h1111_2222_3333_4444;
        ib.rd_addr = {4'd0, 4'd7, 4'd0}; #1;
        chk("b_nobyp_same", ib.rd_data[127:64], 64'h0);
        step(); ib.wr_en = 0; #1;
        chk("b_nobyp_next", ib.rd_data[127:64], 64'h1111_2222_3333_4444);

        // B: fill every index, read back on all ports with duplicates
        for (int i = 0; i < 16; i++) begin
            ib.wr_en = 1; ib.wr_addr = 4'(i); ib.wr_data = {32'hC0DE_0000 + 32'(i), 32'(i * 3)};
            step();
        end
        ib.wr_en = 0;
        for (int i = 0; i < 16; i++) begin
            ib.rd_addr = {4'((i * 5) % 16), 4'(i), 4'(i)}; #1;
            chk($sformatf("b_p0_x%0d", i), ib.rd_data[63:0], fb(i));
            chk($sformatf("b_p1_x%0d", i), ib.rd_data[127:64], fb(i));
            chk($sformatf("b_p2_x%0d", (i * 5) % 16), ib.rd_data[191:128], fb((i * 5) % 16));
        end

        // A: basic write / read, x0 hardwired
        ia.wr_en = 1; ia.wr_addr = 5'd5; ia.wr_data = 32'hDEAD_BEEF; rda(5, 0);
        step(); ia.wr_en = 0; #1;
        chk("a_x5", 64'(ia.rd_data[31:0]), 64'hDEAD_BEEF);
        ia.wr_en = 1; ia.wr_addr = 5'd0; ia.wr_data = 32'h1234; rda(0, 0); #1;
        chk("a_x0_same", 64'(ia.rd_data[31:0]), 64'h0);
        step(); ia.wr_en = 0; #1;
        chk("a_x0_next", 64'(ia.rd_data[31:0]), 64'h0);

        // A: bypass on port 1
        ia.wr_en = 1; ia.wr_addr = 5'd7; ia.wr_data = 32'hA5A5_A5A5; rda(5, 7); #1;
        chk("a_byp_data", 64'(ia.rd_data[63:32]), 64'hA5A5_A5A5);
        chk("a_byp_p0", 64'(ia.rd_data[31:0]), 64'hDEAD_BEEF);
        step(); ia.wr_en = 0; #1;
        chk("a_byp_after", 64'(ia.rd_data[63:32]), 64'hA5A5_A5A5);

        // A: scoreboard reserve / writeback / collision
        ia.rsv_en = 1; ia.rsv_addr = 5'd3; rda(3, 0); #1;
        chk("a_rsv_before", 64'(ia.rd_busy[0]), 64'h0);
        step(); ia.rsv_en = 0; #1;
        chk("a_rsv_busy", 64'(ia.rd_busy[0]), 64'h1);
        ia.wr_en = 1; ia.wr_addr = 5'd3; ia.wr_data = 32'h33; #1;
        chk("a_wb_byp_busy", 64'(ia.rd_busy[0]), 64'h0);
        step(); ia.wr_en = 0; #1;
        chk("a_wb_busy", 64'(ia.rd_busy[0]), 64'h0);
        chk("a_wb_data", 64'(ia.rd_data[31:0]), 64'h33);
        ia.wr_en = 1; ia.wr_data = 32'h44; ia.rsv_en = 1; ia.rsv_addr = 5'd3;
        step(); ia.wr_en = 0; ia.rsv_en = 0; #1;
        chk("a_coll_busy", 64'(ia.rd_busy[0]), 64'h1);
        chk("a_coll_data", 64'(ia.rd_data[31:0]), 64'h44);
        ia.rsv_en = 1; ia.rsv_addr = 5'd0; rda(0, 0);
        step(); ia.rsv_en = 0; #1;
        chk("a_rsv_x0", 64'(ia.rd_busy[0]), 64'h0);

        // A: fill, reserve x9, then clear sweep
        for (int i = 1; i < 32; i++) begin
            ia.wr_en = 1; ia.wr_addr = 5'(i); ia.wr_data = 32'h100 + 32'(i);
            step();
        end
        ia.wr_en = 0; ia.rsv_en = 1; ia.rsv_addr = 5'd9;
        step(); ia.rsv_en = 0; rda(9, 31); #1;
        chk("a_fill_busy9", 64'(ia.rd_busy[0]), 64'h1);
        chk("a_fill_x31", 64'(ia.rd_data[63:32]), 64'h11F);
        ia.clr_req = 1; ia.wr_en = 1; ia.wr_addr = 5'd2; ia.wr_data = 32'hBAD;
        step(); ia.clr_req = 0; ia.wr_addr = 5'd5; ia.wr_data = 32'hFFFF; rda(1, 31); #1;
        chk("a_sweep_ready", 64'(ia.ready), 64'h0);
        cnt = 0;
        while (!ia.ready && cnt < 40) begin
            if (cnt == 5) begin
                chk("a_mid_swept_x1", 64'(ia.rd_data[31:0]), 64'h0);
                chk("a_mid_live_x31", 64'(ia.rd_data[63:32]), 64'h11F);
            end
            cnt++;
            step();
        end
        ia.wr_en = 0; #1;
        chk("a_sweep_cycles", 64'(cnt), 64'd31);
        for (int i = 0; i < 32; i++) begin
            rda(i, 31 - i); #1;
            chk($sformatf("a_clr_x%0d", i), 64'(ia.rd_data), 64'h0);
            chk($sformatf("a_clr_busy_x%0d", i), 64'(ia.rd_busy), 64'h0);
        end

        // A: asynchronous reset in the middle of a sweep (idx 10)
        ia.wr_en = 1; ia.wr_addr = 5'd20; ia.wr_data = 32'h2020; ia.rsv_en = 1; ia.rsv_addr = 5'd21;
        step(); ia.wr_en = 0; ia.rsv_en = 0;
        ia.clr_req = 1;
        step(); ia.clr_req = 0;
        for (int i = 0; i < 9; i++) step();
        rda(20, 21); #1;
        chk("a_pre_rst_ready", 64'(ia.ready), 64'h0);
        chk("a_pre_rst_x20", 64'(ia.rd_data[31:0]), 64'h2020);
        chk("a_pre_rst_busy21", 64'(ia.rd_busy[1]), 64'h1);
        #2 rst_n = 1'b0; #1;
        chk("a_rst_ready", 64'(ia.ready), 64'h1);
        chk("a_rst_data", 64'(ia.rd_data), 64'h0);
        chk("a_rst_busy", 64'(ia.rd_busy), 64'h0);
        ib.rd_addr = {4'd9, 4'd7, 4'd15}; #1;
        chk("b_rst_data", ib.rd_data[191:0] == '0 ? 64'h0 : 64'h1, 64'h0);
        step(); rst_n = 1'b1;
        step();
        chk("a_post_rst_ready", 64'(ia.ready), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
